// File: rtl/neuron_layer_scheduler.sv
// neuron_layer_scheduler
//   Time-multiplexes a single shared neuron datapath across every output of a
//   fully-connected layer. On start the layer input vector is latched once;
//   then, for each neuron index, the weight row and bias are fetched from a
//   synchronous ROM, presented to the neuron, and the neuron's registered
//   result is written to the output buffer. The shared neuron's reset is
//   tied to this block's reset at the parent level.
//
// Ports
//   clk, reset     clock (rising edge), synchronous active-high reset
//   start          one-cycle layer request, honoured only in IDLE
//   input_data     flattened layer input vector (element i at [(i+1)*RES-1 -: RES])
//   busy, done     busy outside IDLE; done pulses for one cycle at layer end
//   rom_en/addr    ROM read request; data returns the following cycle
//   rom_weight/bias  ROM read data
//   neuron_input/weight/bias  registered operands for the shared neuron
//   neuron_output  registered result from the shared neuron
//   out_we/addr/data  output-buffer write port
module neuron_layer_scheduler #(
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_NEURONS = 10,
    parameter int RESOLUTION  = 8,
    parameter int ADDR_WIDTH  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [RESOLUTION*NUM_INPUTS-1:0] input_data,
    output logic                             busy,
    output logic                             done,
    output logic                             rom_en,
    output logic [ADDR_WIDTH-1:0]            rom_addr,
    input  logic [RESOLUTION*NUM_INPUTS-1:0] rom_weight,
    input  logic [RESOLUTION-1:0]            rom_bias,
    output logic [RESOLUTION*NUM_INPUTS-1:0] neuron_input,
    output logic [RESOLUTION*NUM_INPUTS-1:0] neuron_weight,
    output logic [RESOLUTION-1:0]            neuron_bias,
    input  logic [RESOLUTION-1:0]            neuron_output,
    output logic                             out_we,
    output logic [ADDR_WIDTH-1:0]            out_addr,
    output logic [RESOLUTION-1:0]            out_data
);

    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(NUM_NEURONS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LOAD,
        EVAL,
        WRITE,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] index;

    // Strobes are registered: each one is set on the transition into the
    // state that owns it, so it is high for exactly that state's cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            index         <= '0;
            neuron_input  <= '0;
            neuron_weight <= '0;
            neuron_bias   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            rom_en        <= 1'b0;
            out_we        <= 1'b0;
        end else begin
            done   <= 1'b0;
            rom_en <= 1'b0;
            out_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        neuron_input <= input_data;
                        index        <= '0;
                        state        <= ADDR;
                        rom_en       <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                ADDR: begin
                    state <= LOAD;
                end
                LOAD: begin
                    neuron_weight <= rom_weight;
                    neuron_bias   <= rom_bias;
                    state         <= EVAL;
                end
                EVAL: begin
                    // Neuron captures its result at this edge; write next cycle.
                    state  <= WRITE;
                    out_we <= 1'b1;
                end
                WRITE: begin
                    if (index == LAST_INDEX) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        index  <= index + ADDR_WIDTH'(1);
                        state  <= ADDR;
                        rom_en <= 1'b1;
                    end
                end
                DONE: begin
                    // start is not looked at here, so a request in this cycle is dropped.
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // The index is only advanced on leaving WRITE, so it names the current
    // row in ADDR and the current buffer word in WRITE, and is 0 after reset.
    assign rom_addr = index;
    assign out_addr = index;
    assign out_data = out_we ? neuron_output : '0;

endmodule

// File: tb/tb_neuron_layer_scheduler.sv
module tb_neuron_layer_scheduler;

    localparam int NI  = 2;
    localparam int NN  = 3;
    localparam int RES = 8;
    localparam int VW  = NI * RES;
    localparam int LAST_T = 4 * NN + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at time %0t", nm, act, exp, $time);
        end
    endtask

    // Stand-in for the shared neuron: registered dot product scaled by 2^-11
    // (truncating toward zero), plus bias, saturated to the signed word range.
    function automatic logic [7:0] nf(input logic [VW-1:0] x, input logic [VW-1:0] w,
                                      input logic [7:0] b);
        int s;
        logic [7:0] xe, we;
        s = 0;
        for (int i = 0; i < NI; i++) begin
            xe = x[i*RES +: RES];
            we = w[i*RES +: RES];
            s += int'($signed(xe)) * int'($signed(we));
        end
        s = s / 2048 + int'($signed(b));
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return 8'(s);
    endfunction

    // ---------------- main DUT: NUM_INPUTS=2, NUM_NEURONS=3 ----------------
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [VW-1:0]  input_data = '0;
    logic           busy, done, rom_en, out_we;
    logic [1:0]     rom_addr, out_addr;
    logic [VW-1:0]  rom_weight, neuron_input, neuron_weight;
    logic [7:0]     rom_bias, neuron_bias, neuron_output, out_data;

    neuron_layer_scheduler #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .RESOLUTION(RES)) dut (
        .clk(clk), .reset(reset), .start(start), .input_data(input_data),
        .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_weight(rom_weight), .rom_bias(rom_bias),
        .neuron_input(neuron_input), .neuron_weight(neuron_weight),
        .neuron_bias(neuron_bias), .neuron_output(neuron_output),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
    );

    logic [VW-1:0] romw [NN];
    logic [7:0]    romb [NN];
    logic [7:0]    obuf [NN];

    always @(posedge clk) begin
        if (rom_en) begin
            rom_weight <= romw[rom_addr];
            rom_bias   <= romb[rom_addr];
        end
    end

    always @(posedge clk) begin
        if (reset) neuron_output <= '0;
        else       neuron_output <= nf(neuron_input, neuron_weight, neuron_bias);
    end

    // ---------------- reference model ----------------
    // mt = cycles since the edge that accepted start (1..4N+1), -1 when idle.
    int            mt = -1;
    logic [VW-1:0] lat_in = '0;
    logic          opzero = 1'b1;

    always @(posedge clk) begin
        if (reset) begin
            mt     <= -1;
            opzero <= 1'b1;
        end else if (mt >= 1) begin
            mt <= (mt == LAST_T) ? -1 : mt + 1;
        end else if (start) begin
            mt     <= 1;
            lat_in <= input_data;
            opzero <= 1'b0;
        end
    end

    always @(negedge clk) begin
        logic e_rom, e_we;
        int   k;
        e_rom = (mt >= 1) && (mt % 4 == 1) && (mt < LAST_T);
        e_we  = (mt >= 4) && (mt % 4 == 0);
        chk("busy",   32'(busy),   32'(mt >= 1));
        chk("done",   32'(done),   32'(mt == LAST_T));
        chk("rom_en", 32'(rom_en), 32'(e_rom));
        chk("out_we", 32'(out_we), 32'(e_we));
        if (e_rom) chk("rom_addr", 32'(rom_addr), 32'((mt - 1) / 4));
        if (e_we) begin
            k = mt / 4 - 1;
            chk("out_addr", 32'(out_addr), 32'(k));
            chk("out_data", 32'(out_data), 32'(nf(lat_in, romw[k], romb[k])));
        end
        if (mt >= 1) chk("neuron_input", 32'(neuron_input), 32'(lat_in));
        if (mt == -1 && opzero) begin
            chk("rst_ninput",  32'(neuron_input),  32'(0));
            chk("rst_nweight", 32'(neuron_weight), 32'(0));
            chk("rst_nbias",   32'(neuron_bias),   32'(0));
            chk("rst_romaddr", 32'(rom_addr),      32'(0));
            chk("rst_outaddr", 32'(out_addr),      32'(0));
            chk("rst_outdata", 32'(out_data),      32'(0));
        end
        if (out_we && out_addr < 2'(NN)) obuf[out_addr] = out_data;
    end

    // ---------------- single-neuron DUT ----------------
    logic          start1 = 1'b0;
    logic          busy1, done1, rom_en1, out_we1;
    logic [0:0]    rom_addr1, out_addr1;
    logic [VW-1:0] rom_weight1, neuron_input1, neuron_weight1;
    logic [7:0]    rom_bias1, neuron_bias1, neuron_output1, out_data1;

    neuron_layer_scheduler #(.NUM_INPUTS(NI), .NUM_NEURONS(1), .RESOLUTION(RES)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .input_data({8'sd127, 8'sd127}),
        .busy(busy1), .done(done1), .rom_en(rom_en1), .rom_addr(rom_addr1),
        .rom_weight(rom_weight1), .rom_bias(rom_bias1),
        .neuron_input(neuron_input1), .neuron_weight(neuron_weight1),
        .neuron_bias(neuron_bias1), .neuron_output(neuron_output1),
        .out_we(out_we1), .out_addr(out_addr1), .out_data(out_data1)
    );

    always @(posedge clk) begin
        if (rom_en1) begin
            rom_weight1 <= {8'sd127, 8'sd127};
            rom_bias1   <= 8'd0;
        end
    end

    always @(posedge clk) begin
        if (reset) neuron_output1 <= '0;
        else       neuron_output1 <= nf(neuron_input1, neuron_weight1, neuron_bias1);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (mt != -1 && n < 60) begin
            step();
            n++;
        end
        chk({nm, "_idle_timeout"}, 32'(mt == -1), 32'(1));
    endtask

    task automatic load_basic_rom();
        romw[0] = {8'sd127, 8'sd127};   romb[0] = 8'd0;
        romw[1] = {-8'sd127, -8'sd127}; romb[1] = 8'd0;
        romw[2] = '0;                   romb[2] = 8'd0;
    endtask

    task automatic clear_buf();
        for (int i = 0; i < NN; i++) obuf[i] = 8'h55;
    endtask

    task automatic chk_basic_buf(input string nm);
        chk({nm, "_buf0"}, 32'(obuf[0]), 32'h0f);
        chk({nm, "_buf1"}, 32'(obuf[1]), 32'hf1);
        chk({nm, "_buf2"}, 32'(obuf[2]), 32'h00);
    endtask

    initial begin
        load_basic_rom();
        clear_buf();
        repeat (3) step();
        reset = 1'b0;

        // Idle quietness
        repeat (20) step();

        // Basic layer
        input_data = {8'sd127, 8'sd127};
        start = 1'b1; step(); start = 1'b0;
        wait_idle("basic");
        chk_basic_buf("basic");

        // Input latch: input changes in cycle 2
        clear_buf();
        repeat (2) step();
        start = 1'b1; step(); start = 1'b0;
        step(); input_data = '0;
        wait_idle("latch");
        chk_basic_buf("latch");

        // Start while busy, in DONE, then right after
        clear_buf();
        input_data = {8'sd127, 8'sd127};
        repeat (2) step();
        start = 1'b1; step(); start = 1'b0;   // cycle 1
        repeat (2) step();                    // cycle 3
        start = 1'b1; step(); start = 1'b0;   // cycle 4
        repeat (9) step();                    // cycle 13
        start = 1'b1; step();                 // cycle 14
        step(); start = 1'b0;
        wait_idle("restart");
        chk_basic_buf("restart");

        // Reset mid-layer in cycle 6
        clear_buf();
        repeat (2) step();
        start = 1'b1; step(); start = 1'b0;   // cycle 1
        repeat (5) step();                    // cycle 6
        reset = 1'b1; step(); reset = 1'b0;
        chk("abort_idle", 32'(busy), 32'(0));
        chk("abort_buf0", 32'(obuf[0]), 32'h0f);
        chk("abort_buf1", 32'(obuf[1]), 32'h55);
        step();
        start = 1'b1; step(); start = 1'b0;
        wait_idle("after_abort");
        chk_basic_buf("after_abort");

        // Single neuron
        repeat (2) step();
        start1 = 1'b1; step(); start1 = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk("n1_busy",   32'(busy1),   32'(c >= 1 && c <= 5));
            chk("n1_done",   32'(done1),   32'(c == 5));
            chk("n1_rom_en", 32'(rom_en1), 32'(c == 1));
            chk("n1_out_we", 32'(out_we1), 32'(c == 4));
            if (c == 4) begin
                chk("n1_addr", 32'(out_addr1), 32'(0));
                chk("n1_data", 32'(out_data1), 32'h0f);
            end
        end
        step();

        // Randomized layers: random ROM, drifting inputs, stray starts, rare aborts
        for (int it = 0; it < 40; it++) begin
            int abort_at, len;
            for (int r = 0; r < NN; r++) begin
                romw[r] = VW'($urandom);
                romb[r] = 8'($urandom);
            end
            abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, LAST_T)) : -1;
            len = LAST_T + int'($urandom_range(1, 8));
            for (int c = 0; c < len; c++) begin
                start      = (c == 0) || ($urandom_range(0, 7) == 0);
                input_data = VW'($urandom);
                reset      = (c == abort_at);
                step();
            end
            start = 1'b0;
            reset = 1'b0;
            wait_idle("rand");
            repeat ($urandom_range(0, 3)) step();
        end

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
